usb_rx_data_ctrl: RTL and testbench

//  Sequences the DATA-phase receiver of the USB device link layer. After an accepted OUT/SETUP

---
 rtl/usb_rx_data_ctrl_if.sv | 37 +++
 rtl/usb_rx_data_ctrl.sv | 150 +++++++++++++++
 tb/tb_usb_rx_data_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_data_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : usb_rx_data_ctrl_if
// Brief   : Link-layer signals around the USB DATA-phase receive sequencer.
// Rev     : 1.0  initial release
// ============================================================================
interface usb_rx_data_ctrl_if;
  logic       token_valid;
  logic [3:0] token_pid;
  logic       rx_data_on;
  logic       rx_sop_en;
  logic [3:0] rx_pid;
  logic       rx_lt_eop_en;
  logic       crc16_err;
  logic       ep_ready;
  logic       hs_req;
  logic [3:0] hs_pid;
  logic       hs_ack;
  logic       toggle_clr;
  logic       data_toggle;
  logic       rx_done;
  logic       rx_err;
  logic [1:0] err_code;

  modport master (
    output token_valid, token_pid, rx_sop_en, rx_pid, rx_lt_eop_en, crc16_err,
           ep_ready, hs_ack, toggle_clr,
    input  rx_data_on, hs_req, hs_pid, data_toggle, rx_done, rx_err, err_code
  );

  modport slave (
    input  token_valid, token_pid, rx_sop_en, rx_pid, rx_lt_eop_en, crc16_err,
           ep_ready, hs_ack, toggle_clr,
    output rx_data_on, hs_req, hs_pid, data_toggle, rx_done, rx_err, err_code
  );
endinterface
`default_nettype wire

// File: rtl/usb_rx_data_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : usb_rx_data_ctrl
// Brief   : USB device DATA-phase receive sequencer: window, toggle, handshake.
// Rev     : 1.0  initial release
// ============================================================================
module usb_rx_data_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  usb_rx_data_ctrl_if.slave  link_io
);

  localparam logic [3:0] c_PID_OUT   = 4'b0001;
  localparam logic [3:0] c_PID_SETUP = 4'b1101;
  localparam logic [3:0] c_PID_DATA0 = 4'b0011;
  localparam logic [3:0] c_PID_DATA1 = 4'b1011;
  localparam logic [3:0] c_PID_ACK   = 4'b0010;
  localparam logic [3:0] c_PID_NAK   = 4'b1010;

  localparam logic [1:0] c_ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] c_ERR_CRC     = 2'b10;
  localparam logic [1:0] c_ERR_PID     = 2'b11;

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DATA = 2'd1,
    S_RECV      = 2'd2,
    S_HS_SEND   = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             setup_q;
  logic             pkt_tog_q;
  logic             toggle_q;
  logic             toggle_d;
  logic [3:0]       hs_pid_q;
  logic             rx_done_q;
  logic             rx_err_q;
  logic [1:0]       err_code_q;

  logic w_timeout;
  logic w_data_pid;
  logic w_setup_tok;
  logic w_accept;
  logic w_flip;

  assign w_timeout   = (cnt_q == c_CNT_LAST);
  assign w_data_pid  = (link_io.rx_pid == c_PID_DATA0) || (link_io.rx_pid == c_PID_DATA1);
  assign w_setup_tok = (state_q == S_IDLE) && link_io.token_valid &&
                       (link_io.token_pid == c_PID_SETUP);
  // SETUP payloads must always be taken, so endpoint back-pressure only applies to OUT
  assign w_accept    = link_io.ep_ready || setup_q;
  assign w_flip      = (state_q == S_RECV) && link_io.rx_lt_eop_en && !link_io.crc16_err &&
                       w_accept && (pkt_tog_q == toggle_q);

  always_comb begin
    toggle_d = toggle_q;
    if (w_flip)             toggle_d = ~toggle_q;
    if (w_setup_tok)        toggle_d = 1'b0;
    if (link_io.toggle_clr) toggle_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      setup_q    <= 1'b0;
      pkt_tog_q  <= 1'b0;
      toggle_q   <= 1'b0;
      hs_pid_q   <= c_PID_ACK;
      rx_done_q  <= 1'b0;
      rx_err_q   <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      rx_done_q <= 1'b0;
      rx_err_q  <= 1'b0;
      toggle_q  <= toggle_d;
      cnt_q     <= cnt_q + CNT_W'(1);
      case (state_q)
        S_IDLE: begin
          cnt_q   <= '0;
          setup_q <= 1'b0;
          if (link_io.token_valid && (link_io.token_pid == c_PID_OUT || w_setup_tok)) begin
            state_q <= S_WAIT_DATA;
            setup_q <= w_setup_tok;
          end
        end
        S_WAIT_DATA: begin
          if (link_io.rx_sop_en) begin
            if (w_data_pid) begin
              state_q   <= S_RECV;
              cnt_q     <= '0;
              pkt_tog_q <= link_io.rx_pid[3];
            end else begin
              state_q    <= S_IDLE;
              rx_err_q   <= 1'b1;
              err_code_q <= c_ERR_PID;
            end
          end else if (w_timeout) begin
            state_q    <= S_IDLE;
            rx_err_q   <= 1'b1;
            err_code_q <= c_ERR_TIMEOUT;
          end
        end
        S_RECV: begin
          if (link_io.rx_lt_eop_en) begin
            if (link_io.crc16_err) begin
              state_q    <= S_IDLE;
              rx_err_q   <= 1'b1;
              err_code_q <= c_ERR_CRC;
            end else if (!w_accept) begin
              state_q  <= S_HS_SEND;
              hs_pid_q <= c_PID_NAK;
            end else begin
              // A toggle mismatch is a host retry of a packet already taken: ACK it silently
              state_q   <= S_HS_SEND;
              hs_pid_q  <= c_PID_ACK;
              rx_done_q <= (pkt_tog_q == toggle_q);
            end
          end else if (w_timeout) begin
            state_q    <= S_IDLE;
            rx_err_q   <= 1'b1;
            err_code_q <= c_ERR_TIMEOUT;
          end
        end
        S_HS_SEND: begin
          if (link_io.hs_ack) begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign link_io.rx_data_on  = (state_q == S_WAIT_DATA) || (state_q == S_RECV);
  assign link_io.hs_req      = (state_q == S_HS_SEND);
  assign link_io.hs_pid      = hs_pid_q;
  assign link_io.data_toggle = toggle_q;
  assign link_io.rx_done     = rx_done_q;
  assign link_io.rx_err      = rx_err_q;
  assign link_io.err_code    = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_data_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_usb_rx_data_ctrl
// Brief   : Directed and randomized bench for usb_rx_data_ctrl with a link-phase model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_usb_rx_data_ctrl;

  localparam int TIMEOUT = 20;
  localparam int CNT_W   = 8;

  localparam logic [3:0] OUT   = 4'b0001;
  localparam logic [3:0] SETUP = 4'b1101;
  localparam logic [3:0] DATA0 = 4'b0011;
  localparam logic [3:0] DATA1 = 4'b1011;
  localparam logic [3:0] ACK   = 4'b0010;
  localparam logic [3:0] NAK   = 4'b1010;

  localparam int PH_IDLE = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_RECV = 2;
  localparam int PH_HS   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  usb_rx_data_ctrl_if ifc ();

  usb_rx_data_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .link_io (ifc)
  );

  always #5 clk = ~clk;

  // Link-phase model: where the transfer is, how long it has been there, what was promised
  int         m_ph    = PH_IDLE;
  int         m_age   = 0;
  bit         m_setup = 1'b0;
  bit         m_pkt   = 1'b0;
  bit         m_tog   = 1'b0;
  logic [3:0] m_pid   = ACK;
  bit         m_done  = 1'b0;
  bit         m_err   = 1'b0;
  logic [1:0] m_code  = 2'b00;

  task automatic m_abort(input logic [1:0] code);
    m_ph   = PH_IDLE;
    m_err  = 1'b1;
    m_code = code;
  endtask

  task automatic m_reset();
    m_ph = PH_IDLE; m_age = 0; m_setup = 1'b0; m_pkt = 1'b0; m_tog = 1'b0;
    m_pid = ACK; m_done = 1'b0; m_err = 1'b0; m_code = 2'b00;
  endtask

  task automatic m_step();
    bit zero_tog;
    bit flip;
    zero_tog = 1'b0;
    flip     = 1'b0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    if (m_ph == PH_IDLE) begin
      if (ifc.token_valid && (ifc.token_pid == OUT || ifc.token_pid == SETUP)) begin
        m_ph     = PH_WAIT;
        m_age    = 0;
        m_setup  = (ifc.token_pid == SETUP);
        zero_tog = m_setup;
      end
    end else if (m_ph == PH_WAIT) begin
      m_age++;
      if (ifc.rx_sop_en) begin
        if (ifc.rx_pid == DATA0 || ifc.rx_pid == DATA1) begin
          m_ph  = PH_RECV;
          m_age = 0;
          m_pkt = (ifc.rx_pid == DATA1);
        end else begin
          m_abort(2'b11);
        end
      end else if (m_age == TIMEOUT) begin
        m_abort(2'b01);
      end
    end else if (m_ph == PH_RECV) begin
      m_age++;
      if (ifc.rx_lt_eop_en) begin
        if (ifc.crc16_err) begin
          m_abort(2'b10);
        end else if (!ifc.ep_ready && !m_setup) begin
          m_ph  = PH_HS;
          m_pid = NAK;
        end else begin
          m_ph  = PH_HS;
          m_pid = ACK;
          if (m_pkt == m_tog) begin
            m_done = 1'b1;
            flip   = 1'b1;
          end
        end
      end else if (m_age == TIMEOUT) begin
        m_abort(2'b01);
      end
    end else begin
      if (ifc.hs_ack) m_ph = PH_IDLE;
    end
    if (ifc.toggle_clr || zero_tog) m_tog = 1'b0;
    else if (flip)                  m_tog = ~m_tog;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) m_reset();
    else     m_step();
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("rx_data_on",  8'(ifc.rx_data_on),  8'(m_ph == PH_WAIT || m_ph == PH_RECV));
    chk("hs_req",      8'(ifc.hs_req),      8'(m_ph == PH_HS));
    chk("hs_pid",      8'(ifc.hs_pid),      8'(m_pid));
    chk("data_toggle", 8'(ifc.data_toggle), 8'(m_tog));
    chk("rx_done",     8'(ifc.rx_done),     8'(m_done));
    chk("rx_err",      8'(ifc.rx_err),      8'(m_err));
    chk("err_code",    8'(ifc.err_code),    8'(m_code));
  endtask

  initial forever begin
    @(negedge clk);
    if (cmp_en) compare_all();
  end

  // Inputs change 1 time unit after the falling edge, clear of sampling and clocking
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_token(input logic [3:0] pid);
    step(); ifc.token_valid = 1'b1; ifc.token_pid = pid;
    step(); ifc.token_valid = 1'b0;
  endtask

  task automatic pulse_sop(input logic [3:0] pid);
    step(); ifc.rx_sop_en = 1'b1; ifc.rx_pid = pid;
    step(); ifc.rx_sop_en = 1'b0;
  endtask

  task automatic pulse_eop(input bit crc, input bit rdy, input bit clr);
    step(); ifc.rx_lt_eop_en = 1'b1; ifc.crc16_err = crc; ifc.ep_ready = rdy; ifc.toggle_clr = clr;
    step(); ifc.rx_lt_eop_en = 1'b0; ifc.crc16_err = 1'b0; ifc.ep_ready = 1'b1; ifc.toggle_clr = 1'b0;
  endtask

  task automatic pulse_ack();
    step(); ifc.hs_ack = 1'b1;
    step(); ifc.hs_ack = 1'b0;
  endtask

  task automatic clean_out(input logic [3:0] data_pid);
    pulse_token(OUT); idle(2);
    pulse_sop(data_pid); idle(3);
    pulse_eop(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int n;
    ifc.token_valid = 1'b0; ifc.token_pid = 4'h0; ifc.rx_sop_en = 1'b0; ifc.rx_pid = 4'h0;
    ifc.rx_lt_eop_en = 1'b0; ifc.crc16_err = 1'b0; ifc.ep_ready = 1'b1; ifc.hs_ack = 1'b0;
    ifc.toggle_clr = 1'b0;
    idle(2);
    cmp_en = 1'b1;
    idle(2);
    chk("reset_hs_pid", 8'(ifc.hs_pid), 8'h02);
    chk("reset_on",     8'(ifc.rx_data_on), 8'h00);
    rst = 1'b0;
    idle(2);

    // T1
    clean_out(DATA0);
    chk("t1_hs_req", 8'(ifc.hs_req), 8'h01);
    chk("t1_hs_pid", 8'(ifc.hs_pid), 8'h02);
    chk("t1_done",   8'(ifc.rx_done), 8'h01);
    chk("t1_toggle", 8'(ifc.data_toggle), 8'h01);
    step();
    chk("t1_done_one_cycle", 8'(ifc.rx_done), 8'h00);
    idle(2); pulse_ack();
    chk("t1_hs_released", 8'(ifc.hs_req), 8'h00);

    // T2
    clean_out(DATA0);
    chk("t2_hs_req", 8'(ifc.hs_req), 8'h01);
    chk("t2_no_done", 8'(ifc.rx_done), 8'h00);
    chk("t2_toggle", 8'(ifc.data_toggle), 8'h01);
    pulse_ack();

    // T3
    pulse_token(OUT); pulse_sop(DATA1); idle(2);
    pulse_eop(1'b0, 1'b0, 1'b0);
    chk("t3_nak_pid", 8'(ifc.hs_pid), 8'h0a);
    idle(6);
    chk("t3_nak_held_req", 8'(ifc.hs_req), 8'h01);
    chk("t3_nak_held_pid", 8'(ifc.hs_pid), 8'h0a);
    pulse_ack();
    pulse_token(SETUP); pulse_sop(DATA0); idle(2);
    pulse_eop(1'b0, 1'b0, 1'b0);
    chk("t3_setup_ack", 8'(ifc.hs_pid), 8'h02);
    chk("t3_setup_done", 8'(ifc.rx_done), 8'h01);
    chk("t3_setup_toggle", 8'(ifc.data_toggle), 8'h01);
    pulse_ack();

    // T4
    pulse_token(OUT);
    n = 0;
    while (ifc.rx_data_on && n < 3 * TIMEOUT) begin
      n++;
      step();
    end
    chk("t4_window_len", 8'(n), 8'(TIMEOUT));
    chk("t4_err", 8'(ifc.rx_err), 8'h01);
    chk("t4_code", 8'(ifc.err_code), 8'h01);

    // T5
    pulse_token(OUT); idle(1); pulse_sop(4'b0010);
    chk("t5_pid_err", 8'(ifc.rx_err), 8'h01);
    chk("t5_pid_code", 8'(ifc.err_code), 8'h03);
    idle(2);
    pulse_token(OUT); pulse_sop(DATA0); idle(2);
    pulse_eop(1'b1, 1'b1, 1'b0);
    chk("t5_crc_err", 8'(ifc.rx_err), 8'h01);
    chk("t5_crc_code", 8'(ifc.err_code), 8'h02);
    chk("t5_crc_no_hs", 8'(ifc.hs_req), 8'h00);
    chk("t5_crc_toggle", 8'(ifc.data_toggle), 8'h01);
    idle(3);
    chk("t5_code_held", 8'(ifc.err_code), 8'h02);

    // T6
    pulse_token(OUT); pulse_sop(DATA1); idle(1);
    #1 rst = 1'b1;
    #1;
    chk("t6_on_async", 8'(ifc.rx_data_on), 8'h00);
    chk("t6_toggle_rst", 8'(ifc.data_toggle), 8'h00);
    chk("t6_code_rst", 8'(ifc.err_code), 8'h00);
    step(); rst = 1'b0;
    idle(2);
    clean_out(DATA0); pulse_ack();
    pulse_token(OUT); pulse_sop(DATA1); idle(1);
    pulse_eop(1'b0, 1'b1, 1'b1);
    chk("t6_clr_done", 8'(ifc.rx_done), 8'h01);
    chk("t6_clr_wins", 8'(ifc.data_toggle), 8'h00);
    pulse_ack();

    // Randomized traffic, biased by where the model says the link is
    for (int i = 0; i < 5000; i++) begin
      step();
      ifc.token_valid = ($urandom_range(0, (m_ph == PH_IDLE) ? 3 : 31) == 0);
      case ($urandom_range(0, 3))
        0:       ifc.token_pid = OUT;
        1:       ifc.token_pid = SETUP;
        2:       ifc.token_pid = 4'b1001;
        default: ifc.token_pid = 4'($urandom);
      endcase
      ifc.rx_sop_en = ($urandom_range(0, (m_ph == PH_WAIT) ? 5 : 39) == 0);
      case ($urandom_range(0, 7))
        0, 1, 2: ifc.rx_pid = DATA0;
        3, 4, 5: ifc.rx_pid = DATA1;
        default: ifc.rx_pid = 4'($urandom);
      endcase
      ifc.rx_lt_eop_en = ($urandom_range(0, (m_ph == PH_RECV) ? 5 : 39) == 0);
      ifc.crc16_err    = ($urandom_range(0, 5) == 0);
      ifc.ep_ready     = ($urandom_range(0, 3) != 0);
      ifc.hs_ack       = ($urandom_range(0, (m_ph == PH_HS) ? 2 : 19) == 0);
      ifc.toggle_clr   = ($urandom_range(0, 29) == 0);
      rst              = ($urandom_range(0, 599) == 0);
    end
    step();
    rst = 1'b0; ifc.token_valid = 1'b0; ifc.rx_sop_en = 1'b0; ifc.rx_lt_eop_en = 1'b0;
    ifc.hs_ack = 1'b0; ifc.toggle_clr = 1'b0;
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
